// File: rtl/instr_sequencer.sv
// Fetch-decode-execute control sequencer for the 8-bit accumulator datapath.
// Optional SINGLE_STEP_EN build adds a step input and a PAUSE state between instructions.
module instr_sequencer #(
   parameter int OPC_W    = 4,
   parameter int WAIT_MAX = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mem_ready,
   input  logic [OPC_W-1:0] ir_opcode,
   input  logic             zero_flag,
`ifdef SINGLE_STEP_EN
   input  logic             step,
`endif
   output logic             PC_in,
   output logic             PC_out,
   output logic             inc_PC,
   output logic             IR_in,
   output logic             IR_out,
   output logic             MAR_in,
   output logic             MAR_mramout,
   output logic             data_in,
   output logic             data_out,
   output logic             dram_in,
   output logic             dram_out,
   output logic             Y_in,
   output logic             Z_out,
   output logic             en,
   output logic             we,
   output logic [1:0]       alu_op,
   output logic             busy,
   output logic             halted,
   output logic             bus_err
);

   localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(4'h0);
   localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'h1);
   localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4'h2);
   localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'h3);
   localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'h4);
   localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'h5);
   localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(4'h6);
   localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);
   localparam logic [7:0]       WAIT_LAST = 8'(WAIT_MAX - 1);

   typedef enum logic [3:0] {
      IDLE, GET, FETCH, INC, DECODE, ADDR, MEM, ALU, JUMP, HALT, ERR, PAUSE
   } state_t;

   state_t     state, nxt;
   state_t     after_instr;
   logic [7:0] wait_cnt;
   logic       mem_state;

`ifdef SINGLE_STEP_EN
   assign after_instr = PAUSE;
`else
   assign after_instr = GET;
`endif

   assign mem_state = (state == FETCH) || (state == MEM);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state <= nxt;
         if ((nxt == FETCH || nxt == MEM) && nxt != state)
            wait_cnt <= '0;
         else if (mem_state && !mem_ready)
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:   if (start) nxt = GET;
         GET:    nxt = FETCH;
         FETCH: begin
            if (mem_ready)                   nxt = INC;
            else if (wait_cnt == WAIT_LAST)  nxt = ERR;
         end
         INC:    nxt = DECODE;
         DECODE: begin
            case (ir_opcode)
               OP_NOP:                         nxt = after_instr;
               OP_HLT:                         nxt = HALT;
               OP_JMP:                         nxt = JUMP;
               OP_JZ:                          nxt = zero_flag ? JUMP : after_instr;
               OP_LDA, OP_STA, OP_ADD, OP_SUB: nxt = ADDR;
               default:                        nxt = ERR;
            endcase
         end
         ADDR:   nxt = MEM;
         MEM: begin
            if (mem_ready)
               nxt = (ir_opcode == OP_ADD || ir_opcode == OP_SUB) ? ALU : after_instr;
            else if (wait_cnt == WAIT_LAST)
               nxt = ERR;
         end
         ALU:    nxt = after_instr;
         JUMP:   nxt = after_instr;
         HALT:   if (start) nxt = GET;
         ERR:    nxt = ERR;
`ifdef SINGLE_STEP_EN
         PAUSE:  if (step) nxt = GET;
`endif
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      PC_in       = 1'b0;
      PC_out      = 1'b0;
      inc_PC      = 1'b0;
      IR_in       = 1'b0;
      IR_out      = 1'b0;
      MAR_in      = 1'b0;
      MAR_mramout = 1'b0;
      data_in     = 1'b0;
      data_out    = 1'b0;
      dram_in     = 1'b0;
      dram_out    = 1'b0;
      Y_in        = 1'b0;
      Z_out       = 1'b0;
      en          = 1'b0;
      we          = 1'b0;
      alu_op      = 2'b00;
      busy        = !(state inside {IDLE, HALT, ERR, PAUSE});
      halted      = (state == HALT);
      bus_err     = (state == ERR);
      case (state)
         GET: begin
            PC_out = 1'b1;
            MAR_in = 1'b1;
         end
         FETCH: begin
            MAR_mramout = 1'b1;
            en          = 1'b1;
            dram_out    = 1'b1;
            IR_in       = mem_ready;
         end
         INC:  inc_PC = 1'b1;
         ADDR: begin
            IR_out = 1'b1;
            MAR_in = 1'b1;
         end
         MEM: begin
            MAR_mramout = 1'b1;
            en          = 1'b1;
            case (ir_opcode)
               OP_LDA: begin
                  dram_out = 1'b1;
                  data_in  = mem_ready;
               end
               OP_STA: begin
                  data_out = 1'b1;
                  dram_in  = 1'b1;
                  we       = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  dram_out = 1'b1;
                  Y_in     = mem_ready;
               end
               default: ;
            endcase
         end
         ALU: begin
            alu_op  = (ir_opcode == OP_SUB) ? 2'b10 : 2'b01;
            Z_out   = 1'b1;
            data_in = 1'b1;
         end
         JUMP: begin
            IR_out = 1'b1;
            PC_in  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
